// File: rtl/game_life_if.sv
// Bundle between the game life controller and the rest of the game:
// square/obstacle status in, game-state flags and counters out.
interface game_life_if #(
  parameter int COORD_W = 10,
  parameter int SIZE_W  = 10,
  parameter int LIFE_W  = 3,
  parameter int SCORE_W = 14
);
  logic               KEY_START;
  logic               DROP_READY;
  logic [COORD_W-1:0] SQUARE_Y;
  logic [SIZE_W-1:0]  SQUARE_SIZE;
  logic               OBST_IN_COLUMN;
  logic [COORD_W-1:0] GAP_TOP;
  logic [COORD_W-1:0] GAP_BOTTOM;
  logic               OBST_PASSED;
  logic               BONUS_HIT;
  logic               START;
  logic               HURT;
  logic               RECOVER;
  logic               INVINCIBLE;
  logic               OVER;
  logic [LIFE_W-1:0]  LIVES;
  logic [SCORE_W-1:0] SCORE;

  modport master (
    output KEY_START, DROP_READY, SQUARE_Y, SQUARE_SIZE, OBST_IN_COLUMN,
           GAP_TOP, GAP_BOTTOM, OBST_PASSED, BONUS_HIT,
    input  START, HURT, RECOVER, INVINCIBLE, OVER, LIVES, SCORE
  );

  modport slave (
    input  KEY_START, DROP_READY, SQUARE_Y, SQUARE_SIZE, OBST_IN_COLUMN,
           GAP_TOP, GAP_BOTTOM, OBST_PASSED, BONUS_HIT,
    output START, HURT, RECOVER, INVINCIBLE, OVER, LIVES, SCORE
  );
endinterface

// File: rtl/game_life_controller.sv
// Game-side state machine: start/drop sequencing, collision detection,
// lives with invincibility window, bonus recovery and saturating score.
module game_life_controller #(
  parameter int COORD_W    = 10,
  parameter int SIZE_W     = 10,
  parameter int LIFE_W     = 3,
  parameter int INIT_LIVES = 3,
  parameter int MAX_LIVES  = 5,
  parameter int INV_TICKS  = 200,
  parameter int SCORE_W    = 14
) (
  input  logic        CLK,
  input  logic        RESET,
  game_life_if.slave  bus
);
  localparam int SPAN_W = ((COORD_W > SIZE_W) ? COORD_W : SIZE_W) + 1;
  localparam int TMR_W  = $clog2(INV_TICKS + 1);

  typedef enum logic [1:0] {IDLE, WAIT_DROP, PLAY, GAME_OVER} state_t;

  state_t             state_q, state_d;
  logic               key_prev_q;
  logic [LIFE_W-1:0]  lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               inv_q, inv_d;
  logic               hurt_q, hurt_d;
  logic               rec_q, rec_d;
  logic               start_q, start_d;
  logic               over_q, over_d;

  logic [SPAN_W-1:0]  size_eff, span_bot;
  logic               collide, hit, start_edge, fatal;

  // Span is widened by one bit so a square hanging off the bottom never wraps.
  assign size_eff   = (bus.SQUARE_SIZE == '0) ? SPAN_W'(1) : SPAN_W'(bus.SQUARE_SIZE);
  assign span_bot   = SPAN_W'(bus.SQUARE_Y) + size_eff - SPAN_W'(1);
  assign collide    = bus.OBST_IN_COLUMN &
                      ((bus.SQUARE_Y < bus.GAP_TOP) | (span_bot > SPAN_W'(bus.GAP_BOTTOM)));
  assign hit        = collide & ~inv_q;
  assign start_edge = bus.KEY_START & ~key_prev_q;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    tmr_d   = tmr_q;
    inv_d   = inv_q;
    hurt_d  = 1'b0;
    rec_d   = 1'b0;
    over_d  = over_q;
    fatal   = 1'b0;

    if (inv_q) begin
      if (tmr_q == '0) inv_d = 1'b0;
      else             tmr_d = tmr_q - TMR_W'(1);
    end

    case (state_q)
      IDLE: if (start_edge) begin
        state_d = WAIT_DROP;
        lives_d = LIFE_W'(INIT_LIVES);
        score_d = '0;
      end
      WAIT_DROP: if (bus.DROP_READY) state_d = PLAY;
      PLAY: begin
        if (hit) begin
          hurt_d = 1'b1;
          inv_d  = 1'b1;
          tmr_d  = TMR_W'(INV_TICKS - 1);
          // A simultaneous bonus cancels the life loss, so it can never be fatal.
          if (bus.BONUS_HIT) rec_d = 1'b1;
          else begin
            lives_d = lives_q - LIFE_W'(1);
            if (lives_q == LIFE_W'(1)) begin
              fatal   = 1'b1;
              state_d = GAME_OVER;
              over_d  = 1'b1;
              inv_d   = 1'b0;
              tmr_d   = '0;
            end
          end
        end else if (bus.BONUS_HIT && (lives_q < LIFE_W'(MAX_LIVES))) begin
          rec_d   = 1'b1;
          lives_d = lives_q + LIFE_W'(1);
        end
        if (bus.OBST_PASSED && !fatal && (score_q != '1))
          score_d = score_q + SCORE_W'(1);
      end
      default: begin
        inv_d = 1'b0;
        tmr_d = '0;
      end
    endcase

    start_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      key_prev_q <= 1'b1;
      lives_q    <= LIFE_W'(INIT_LIVES);
      score_q    <= '0;
      tmr_q      <= '0;
      inv_q      <= 1'b0;
      hurt_q     <= 1'b0;
      rec_q      <= 1'b0;
      start_q    <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= bus.KEY_START;
      lives_q    <= lives_d;
      score_q    <= score_d;
      tmr_q      <= tmr_d;
      inv_q      <= inv_d;
      hurt_q     <= hurt_d;
      rec_q      <= rec_d;
      start_q    <= start_d;
      over_q     <= over_d;
    end
  end

  assign bus.START      = start_q;
  assign bus.HURT       = hurt_q;
  assign bus.RECOVER    = rec_q;
  assign bus.INVINCIBLE = inv_q;
  assign bus.OVER       = over_q;
  assign bus.LIVES      = lives_q;
  assign bus.SCORE      = score_q;
endmodule

// File: tb/tb_game_life_controller.sv
// Directed + random bench for game_life_controller against a rule-level model;
// a second instance with a 2-bit score shares the inputs to exercise saturation.
module tb_game_life_controller;
  localparam int INV_TICKS = 200;
  localparam int INIT_L    = 3;
  localparam int MAX_L     = 5;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  game_life_if b1 ();
  game_life_if #(.SCORE_W(2)) b2 ();

  assign b2.KEY_START      = b1.KEY_START;
  assign b2.DROP_READY     = b1.DROP_READY;
  assign b2.SQUARE_Y       = b1.SQUARE_Y;
  assign b2.SQUARE_SIZE    = b1.SQUARE_SIZE;
  assign b2.OBST_IN_COLUMN = b1.OBST_IN_COLUMN;
  assign b2.GAP_TOP        = b1.GAP_TOP;
  assign b2.GAP_BOTTOM     = b1.GAP_BOTTOM;
  assign b2.OBST_PASSED    = b1.OBST_PASSED;
  assign b2.BONUS_HIT      = b1.BONUS_HIT;

  game_life_controller dut (.CLK(CLK), .RESET(RESET), .bus(b1));
  game_life_controller #(.SCORE_W(2)) dut2 (.CLK(CLK), .RESET(RESET), .bus(b2));

  int n_vec = 0;
  int n_err = 0;

  // Rule-level model: mode 0 idle, 1 waiting for drop, 2 playing, 3 over.
  int m_mode, m_lives, m_score, m_score2, m_inv_left;
  bit m_hurt, m_rec, m_keyprev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int bot, sz;
    bit col, inv, hit, edge_k;
    if (RESET) begin
      m_mode = 0; m_lives = INIT_L; m_score = 0; m_score2 = 0;
      m_inv_left = 0; m_hurt = 0; m_rec = 0; m_keyprev = 1;
      return;
    end
    m_hurt = 0; m_rec = 0;
    edge_k = b1.KEY_START && !m_keyprev;
    m_keyprev = b1.KEY_START;
    sz  = (b1.SQUARE_SIZE == 0) ? 1 : int'(b1.SQUARE_SIZE);
    bot = int'(b1.SQUARE_Y) + sz - 1;
    col = b1.OBST_IN_COLUMN && ((int'(b1.SQUARE_Y) < int'(b1.GAP_TOP)) || (bot > int'(b1.GAP_BOTTOM)));
    case (m_mode)
      0: if (edge_k) begin m_mode = 1; m_lives = INIT_L; m_score = 0; m_score2 = 0; end
      1: if (b1.DROP_READY) m_mode = 2;
      2: begin
        inv = (m_inv_left > 0);
        hit = col && !inv;
        if (m_inv_left > 0) m_inv_left--;
        if (hit) begin
          m_hurt = 1;
          m_inv_left = INV_TICKS;
          if (b1.BONUS_HIT) m_rec = 1;
          else begin
            m_lives--;
            if (m_lives == 0) begin m_mode = 3; m_inv_left = 0; end
          end
        end else if (b1.BONUS_HIT && m_lives < MAX_L) begin
          m_rec = 1; m_lives++;
        end
        if (b1.OBST_PASSED && m_mode == 2) begin
          if (m_score < 16383) m_score++;
          if (m_score2 < 3) m_score2++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    chk("START",      b1.START,      m_mode != 0);
    chk("HURT",       b1.HURT,       m_hurt);
    chk("RECOVER",    b1.RECOVER,    m_rec);
    chk("INVINCIBLE", b1.INVINCIBLE, m_inv_left > 0);
    chk("OVER",       b1.OVER,       m_mode == 3);
    chk("LIVES",      b1.LIVES,      m_lives);
    chk("SCORE",      b1.SCORE,      m_score);
    chk("SCORE2",     b2.SCORE,      m_score2);
    chk("LIVES2",     b2.LIVES,      m_lives);
  endtask

  task automatic quiet();
    b1.KEY_START = 0; b1.DROP_READY = 0; b1.OBST_IN_COLUMN = 0;
    b1.OBST_PASSED = 0; b1.BONUS_HIT = 0;
    b1.SQUARE_Y = 10'd100; b1.SQUARE_SIZE = 10'd12;
    b1.GAP_TOP = 10'd90; b1.GAP_BOTTOM = 10'd120;
  endtask

  task automatic start_game();
    b1.KEY_START = 1; tick();
    b1.KEY_START = 0; b1.DROP_READY = 1; tick();
    b1.DROP_READY = 0;
  endtask

  task automatic hit_and_wait();
    b1.OBST_IN_COLUMN = 1; b1.SQUARE_Y = 10'd115; tick();
    b1.OBST_IN_COLUMN = 0; b1.SQUARE_Y = 10'd100;
    repeat (INV_TICKS + 1) tick();
  endtask

  initial begin
    int inv_hi, hurt_seen;
    int exp2 [5] = '{1, 2, 3, 3, 3};
    quiet();
    RESET = 1; b1.KEY_START = 1;
    repeat (2) tick();
    chk("rst_lives", b1.LIVES, INIT_L);
    chk("rst_start", b1.START, 0);
    RESET = 0;
    repeat (3) tick();
    chk("held_key_no_start", b1.START, 0);
    b1.KEY_START = 0; tick();
    b1.KEY_START = 1; tick();
    chk("press_start", b1.START, 1);
    b1.KEY_START = 0; b1.DROP_READY = 1; tick();
    b1.DROP_READY = 0;

    // Inside the gap: no hit; then bottom edge pokes out.
    b1.OBST_IN_COLUMN = 1;
    repeat (3) tick();
    chk("in_gap_no_hurt", b1.HURT, 0);
    b1.SQUARE_Y = 10'd115; tick();
    chk("hit_hurt", b1.HURT, 1);
    chk("hit_lives", b1.LIVES, 2);
    inv_hi = 1; hurt_seen = 0;
    repeat (INV_TICKS - 1) begin
      tick();
      inv_hi += b1.INVINCIBLE;
      hurt_seen += b1.HURT;
    end
    b1.OBST_IN_COLUMN = 0; tick();
    chk("inv_window_len", inv_hi, INV_TICKS);
    chk("inv_no_rehit", hurt_seen, 0);
    chk("inv_cleared", b1.INVINCIBLE, 0);

    hit_and_wait();
    chk("lives_one", b1.LIVES, 1);
    b1.OBST_IN_COLUMN = 1; b1.SQUARE_Y = 10'd115; b1.OBST_PASSED = 1; tick();
    chk("fatal_over", b1.OVER, 1);
    chk("fatal_inv", b1.INVINCIBLE, 0);
    chk("fatal_lives", b1.LIVES, 0);
    chk("fatal_no_score", b1.SCORE, 0);
    b1.OBST_PASSED = 0;
    for (int i = 0; i < 10; i++) begin
      b1.KEY_START = i[0]; b1.BONUS_HIT = i[1];
      tick();
    end
    quiet();
    chk("over_held", b1.OVER, 1);
    RESET = 1; tick(); RESET = 0;
    chk("rst_over", b1.OVER, 0);
    chk("rst_lives3", b1.LIVES, INIT_L);

    // Bonus saturation and recovery.
    tick(); start_game();
    b1.BONUS_HIT = 1; repeat (2) tick();
    chk("bonus_to_max", b1.LIVES, MAX_L);
    tick();
    chk("bonus_at_max", b1.RECOVER, 0);
    b1.BONUS_HIT = 0;
    hit_and_wait();
    b1.BONUS_HIT = 1; tick(); b1.BONUS_HIT = 0;
    chk("bonus_rec", b1.RECOVER, 1);
    chk("bonus_lives", b1.LIVES, MAX_L);
    repeat (4) hit_and_wait();
    chk("down_to_one", b1.LIVES, 1);
    b1.OBST_IN_COLUMN = 1; b1.SQUARE_Y = 10'd115; b1.BONUS_HIT = 1; tick();
    chk("hb_hurt", b1.HURT, 1);
    chk("hb_rec", b1.RECOVER, 1);
    chk("hb_lives", b1.LIVES, 1);
    chk("hb_over", b1.OVER, 0);
    chk("hb_inv", b1.INVINCIBLE, 1);
    quiet();
    repeat (INV_TICKS + 1) tick();

    for (int i = 0; i < 5; i++) begin
      b1.OBST_PASSED = 1; tick(); b1.OBST_PASSED = 0;
      chk("score2_sat", b2.SCORE, exp2[i]);
      tick();
    end
    chk("score_five", b1.SCORE, 5);

    // Passes while waiting for the drop are ignored; reset mid-play clears all.
    RESET = 1; tick(); RESET = 0; tick();
    b1.KEY_START = 1; tick(); b1.KEY_START = 0;
    b1.OBST_PASSED = 1; repeat (3) tick();
    chk("wait_no_score", b1.SCORE, 0);
    b1.OBST_PASSED = 0; b1.DROP_READY = 1; tick(); b1.DROP_READY = 0;
    b1.OBST_PASSED = 1; tick();
    chk("play_score", b1.SCORE, 1);
    b1.OBST_IN_COLUMN = 1; b1.SQUARE_Y = 10'd115; RESET = 1; tick();
    chk("midrst_start", b1.START, 0);
    chk("midrst_score", b1.SCORE, 0);
    chk("midrst_hurt", b1.HURT, 0);
    RESET = 0; quiet();

    for (int i = 0; i < 4000; i++) begin
      RESET             = ($urandom % 300) == 0;
      b1.KEY_START      = ($urandom % 6) == 0;
      b1.DROP_READY     = ($urandom % 4) == 0;
      b1.OBST_IN_COLUMN = ($urandom % 3) == 0;
      b1.SQUARE_Y       = 10'($urandom_range(0, 200));
      b1.SQUARE_SIZE    = 10'($urandom_range(0, 40));
      b1.GAP_TOP        = 10'($urandom_range(0, 150));
      b1.GAP_BOTTOM     = b1.GAP_TOP + 10'($urandom_range(0, 100));
      b1.OBST_PASSED    = ($urandom % 5) == 0;
      b1.BONUS_HIT      = ($urandom % 10) == 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
